// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } btn_db_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
    localparam int unsigned N_BTN_DEF           = 4;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bus: raw pins in, debounced level/pulses/pending/irq out.
interface btn_debounce_if #(
    parameter int unsigned N_BTN = btn_debounce_pkg::N_BTN_DEF
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] evt_pending;
    logic [N_BTN-1:0] evt_clr;
    logic [N_BTN-1:0] irq_en;
    logic             irq;

    modport master (
        output btn_raw, evt_clr, irq_en,
        input  btn_level, btn_press, btn_release, evt_pending, irq
    );

    modport slave (
        input  btn_raw, evt_clr, irq_en,
        output btn_level, btn_press, btn_release, evt_pending, irq
    );

endinterface

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchronizer, 4-state debounce FSM with stability counter,
// registered level and one-cycle press/release pulses.
module btn_debounce_cell
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_riscv,
    input  logic hard_rst_in_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_press_set
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             w_sync;
    btn_db_state_e    r_state;
    btn_db_state_e    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;

    assign w_sync = r_sync[1];

    always_ff @(posedge clk_riscv or negedge hard_rst_in_n) begin
        if (!hard_rst_in_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    always_ff @(posedge clk_riscv or negedge hard_rst_in_n) begin
        if (!hard_rst_in_n) begin
            r_state   <= STABLE_LO;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Level and pulses are derived from the next state so they register on the
    // same edge the FSM enters the new stable state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_sync) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!w_sync) begin
                    w_state_nxt = STABLE_LO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!w_sync) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (w_sync) begin
                    w_state_nxt = STABLE_HI;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = STABLE_LO;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
            end
        endcase
        w_level_nxt = (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
    end

    assign o_level     = r_level;
    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_press_set = w_press_nxt;

endmodule

// File: rtl/btn_debounce.sv
// N_BTN independent debounce cells plus sticky press flags and a level irq.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic           clk_riscv,
    input  logic           hard_rst_in_n,
    btn_debounce_if.slave  btn_bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    if ((DEBOUNCE_CYCLES < 2) || (CNT_W < 1)) begin : g_param_chk
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    logic [N_BTN-1:0] w_press_set;
    logic [N_BTN-1:0] r_pend;
    logic             r_irq;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk_riscv     (clk_riscv),
            .hard_rst_in_n (hard_rst_in_n),
            .i_raw         (btn_bus.btn_raw[gi]),
            .o_level       (w_level[gi]),
            .o_press       (w_press[gi]),
            .o_release     (w_release[gi]),
            .o_press_set   (w_press_set[gi])
        );
    end

    // Pending sets on the same edge btn_press rises; set wins over clear.
    always_ff @(posedge clk_riscv or negedge hard_rst_in_n) begin
        if (!hard_rst_in_n) begin
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~btn_bus.evt_clr) | w_press_set;
            r_irq  <= |(r_pend & btn_bus.irq_en);
        end
    end

    assign btn_bus.btn_level   = w_level;
    assign btn_bus.btn_press   = w_press;
    assign btn_bus.btn_release = w_release;
    assign btn_bus.evt_pending = r_pend;
    assign btn_bus.irq         = r_irq;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (N_BTN=4, DEBOUNCE_CYCLES=4) with a
// per-cycle expected-output scoreboard.
module tb_btn_debounce;

    localparam logic [3:0] IEN = 4'b0001;

    typedef struct {
        string      tag;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] pnd;
        logic       irq;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];

    logic [3:0] m_lvl;
    logic [3:0] m_pnd;
    logic [3:0] p_pnd;

    btn_debounce_if #(.N_BTN(4)) btn_bus ();

    btn_debounce #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_riscv     (clk),
        .hard_rst_in_n (rst_n),
        .btn_bus       (btn_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".lvl"}, btn_bus.btn_level, 4'b0);
        chk({tag, ".prs"}, btn_bus.btn_press, 4'b0);
        chk({tag, ".rel"}, btn_bus.btn_release, 4'b0);
        chk({tag, ".pnd"}, btn_bus.evt_pending, 4'b0);
        chk({tag, ".irq"}, {3'b0, btn_bus.irq}, 4'b0);
    endtask

    // One clock: queue what this edge must produce, then compare after it.
    task automatic cyc(input string tag, input logic [3:0] prs = 4'b0,
                       input logic [3:0] rel = 4'b0);
        exp_t e;
        exp_t g;
        e.tag = tag;
        e.lvl = m_lvl;
        e.prs = prs;
        e.rel = rel;
        e.pnd = m_pnd;
        e.irq = |(p_pnd & IEN);
        p_pnd = m_pnd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({g.tag, ".lvl"}, btn_bus.btn_level, g.lvl);
        chk({g.tag, ".prs"}, btn_bus.btn_press, g.prs);
        chk({g.tag, ".rel"}, btn_bus.btn_release, g.rel);
        chk({g.tag, ".pnd"}, btn_bus.evt_pending, g.pnd);
        chk({g.tag, ".irq"}, {3'b0, btn_bus.irq}, {3'b0, g.irq});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn_bus.btn_raw = '0;
        btn_bus.evt_clr = '0;
        btn_bus.irq_en  = IEN;
        m_lvl = '0;
        m_pnd = '0;
        p_pnd = '0;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // clean press on btn0: level/press at edge 7, irq one edge later
        btn_bus.btn_raw[0] = 1'b1;
        repeat (6) cyc("press0_wait");
        m_lvl[0] = 1'b1; m_pnd[0] = 1'b1;
        cyc("press0_edge", 4'b0001);
        repeat (3) cyc("press0_hold");

        // glitches on btn1: 3 and 4 samples high are rejected
        btn_bus.btn_raw[1] = 1'b1;
        repeat (3) cyc("glitch3_hi");
        btn_bus.btn_raw[1] = 1'b0;
        repeat (8) cyc("glitch3_lo");
        btn_bus.btn_raw[1] = 1'b1;
        repeat (4) cyc("glitch4_hi");
        btn_bus.btn_raw[1] = 1'b0;
        repeat (8) cyc("glitch4_lo");

        // 5 samples high is the shortest accepted pulse
        btn_bus.btn_raw[1] = 1'b1;
        repeat (5) cyc("pulse5_hi");
        btn_bus.btn_raw[1] = 1'b0;
        cyc("pulse5_lo");
        m_lvl[1] = 1'b1; m_pnd[1] = 1'b1;
        cyc("pulse5_press", 4'b0010);
        repeat (4) cyc("pulse5_wait");
        m_lvl[1] = 1'b0;
        cyc("pulse5_rel", 4'b0000, 4'b0010);
        cyc("pulse5_idle");

        btn_bus.evt_clr = 4'b0010; m_pnd[1] = 1'b0;
        cyc("clr1");
        btn_bus.evt_clr = '0;
        cyc("clr1_after");

        // bounce on btn2: 1,0,1,0 then steady 1
        btn_bus.btn_raw[2] = 1'b1; cyc("bounce_1");
        btn_bus.btn_raw[2] = 1'b0; cyc("bounce_0");
        btn_bus.btn_raw[2] = 1'b1; cyc("bounce_1b");
        btn_bus.btn_raw[2] = 1'b0; cyc("bounce_0b");
        btn_bus.btn_raw[2] = 1'b1;
        repeat (6) cyc("bounce_wait");
        m_lvl[2] = 1'b1; m_pnd[2] = 1'b1;
        cyc("bounce_press", 4'b0100);
        repeat (3) cyc("bounce_hold");

        // release btn0, then re-press with a coincident clear
        btn_bus.btn_raw[0] = 1'b0;
        repeat (6) cyc("rel0_wait");
        m_lvl[0] = 1'b0;
        cyc("rel0_edge", 4'b0000, 4'b0001);
        cyc("rel0_after");
        btn_bus.btn_raw[0] = 1'b1;
        repeat (6) cyc("repress_wait");
        btn_bus.evt_clr = 4'b0001; m_lvl[0] = 1'b1;
        cyc("repress_clr", 4'b0001);
        btn_bus.evt_clr = '0;
        cyc("repress_hold");

        // lone clear drops pending, irq follows one edge later
        btn_bus.evt_clr = 4'b0001; m_pnd[0] = 1'b0;
        cyc("lone_clr");
        btn_bus.evt_clr = '0;
        cyc("lone_clr_irq");
        cyc("lone_clr_idle");

        // reset in the middle of btn3's wait
        btn_bus.btn_raw[3] = 1'b1;
        repeat (3) cyc("rstw_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        btn_bus.btn_raw = 4'hF;
        rst_n = 1'b1;
        m_lvl = '0; m_pnd = '0; p_pnd = '0;
        repeat (6) cyc("rstrel_wait");
        m_lvl = 4'hF; m_pnd = 4'hF;
        cyc("rstrel_press", 4'hF);
        cyc("all_hold");

        // simultaneous release of all buttons
        btn_bus.btn_raw = '0;
        repeat (6) cyc("allrel_wait");
        m_lvl = '0;
        cyc("allrel_edge", 4'b0000, 4'hF);
        cyc("allrel_after");

        btn_bus.evt_clr = 4'hF; m_pnd = '0;
        cyc("clr_all");
        btn_bus.evt_clr = '0;
        repeat (2) cyc("clr_all_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of push-button inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, stable-input cycles required before accepting a change (10 ms at 25 MHz).
REQ-003 SHALL have localparam CNT_W = $clog2(DEBOUNCE_CYCLES), the width of the per-button counter.
REQ-004 SHALL have port clk_riscv, input, 1, system clock; all state is updated on its rising edge.
REQ-005 SHALL have port hard_rst_in_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn_raw, input, N_BTN, asynchronous raw button pins, active-high.
REQ-007 SHALL have port btn_level, output, N_BTN, debounced button level.
REQ-008 SHALL have port btn_press, output, N_BTN, one-cycle pulse on each accepted 0->1 transition.
REQ-009 SHALL have port btn_release, output, N_BTN, one-cycle pulse on each accepted 1->0 transition.
REQ-010 SHALL have port evt_pending, output, N_BTN, sticky per-button press flag.
REQ-011 SHALL have port evt_clr, input, N_BTN, write-1-to-clear strobe for evt_pending.
REQ-012 SHALL have port irq_en, input, N_BTN, per-button interrupt enable.
REQ-013 SHALL have port irq, output, 1, level interrupt request to the PIO interrupt line.

Function
REQ-014 SHALL pass each btn_raw bit through a 2-flop synchronizer; only the second-flop output (sync) feeds the FSM.
REQ-015 SHALL run one 4-state FSM per button with states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO.
REQ-016 In STABLE_LO with sync=1, SHALL go to WAIT_HI and clear the counter to 0.
REQ-017 In WAIT_HI with sync=0, SHALL return to STABLE_LO with no event (glitch rejected).
REQ-018 In WAIT_HI with sync=1 and counter<DEBOUNCE_CYCLES-1, SHALL increment the counter.
REQ-019 In WAIT_HI with sync=1 and counter==DEBOUNCE_CYCLES-1, SHALL go to STABLE_HI.
REQ-020 REQ-016 to REQ-019 SHALL apply symmetrically to STABLE_HI and WAIT_LO with polarity inverted.
REQ-021 btn_level SHALL be registered: 1 in STABLE_HI and WAIT_LO, 0 in STABLE_LO and WAIT_HI.
REQ-022 btn_press / btn_release SHALL assert for exactly one cycle, coincident with the edge at which btn_level changes.
REQ-023 Latency: with raw stable from edge 1 (first sampling edge), btn_level SHALL change at edge DEBOUNCE_CYCLES+3.
REQ-024 A raw pulse that is stable for fewer than DEBOUNCE_CYCLES+1 edges SHALL produce no level change and no pulse.
REQ-025 The counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 only transiently, because the FSM leaves the WAIT state on that edge.
REQ-026 evt_pending[i] SHALL be set on btn_press[i] and cleared on evt_clr[i]; a simultaneous set and clear SHALL leave it set.
REQ-027 irq SHALL be registered, equal to |(evt_pending & irq_en) delayed one cycle.
REQ-028 Button bits SHALL be fully independent; simultaneous events on several bits SHALL all be reported in the same cycle.

Reset
REQ-029 On hard_rst_in_n=0, SHALL immediately (asynchronously) clear: synchronizers, counters and all outputs to 0; every FSM SHALL go to STABLE_LO.
REQ-030 Reset asserted mid-debounce SHALL abort without an event; a button held through reset release SHALL produce btn_press after the REQ-023 latency.
REQ-031 Deassertion is assumed synchronous to clk_riscv; no internal reset synchronizer SHALL be added.

Structure
REQ-032 Package btn_debounce_pkg SHALL hold the state enum typedef (btn_db_state_e) and the default DEBOUNCE_CYCLES constant.
REQ-033 The per-bit synchronizer, FSM, counter and pulse logic SHALL be sub-module btn_debounce_cell, instantiated N_BTN times by a generate loop; pending/irq logic SHALL reside in the top.
REQ-034 SHALL include an elaboration-time assertion that DEBOUNCE_CYCLES>=2.

Verification (DEBOUNCE_CYCLES=4, N_BTN=4)
REQ-035 Clean press: btn_raw[0] 0->1 sampled at edge 1 -> btn_level[0]=1 and btn_press[0]=1 at edge 7 only; evt_pending[0]=1 from edge 7.
REQ-036 Glitch: btn_raw[1] high for 3 cycles -> btn_level, btn_press and evt_pending stay 0.
REQ-037 Bounce: btn_raw[2] toggles 1,0,1,0 then stays 1 -> exactly one btn_press, 7 edges after the final rise.
REQ-038 Pending/irq: irq_en=4'b0001, press btn0 -> irq=1 one cycle after evt_pending; evt_clr[0] pulse coincident with a new press -> pending stays 1; a lone evt_clr -> irq=0 one cycle after pending clears.
REQ-039 Reset mid-wait: assert hard_rst_in_n low at edge 4 of a press -> all outputs 0 immediately; raw held high -> btn_press 7 edges after reset release.
REQ-040 Simultaneous: all four buttons released after stable high -> btn_release=4'hF for exactly one cycle.
